// File: rtl/core_tb_pkg.sv
// Shared types for the core trace checker: checker states and error codes.
package core_tb_pkg;

   typedef enum logic [2:0] {
      ST_HOLD,
      ST_RUN,
      ST_PASS,
      ST_FAIL,
      ST_TIMEOUT
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_PC      = 2'd1;
   localparam logic [1:0] ERR_DATA    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/core_rst_seq.sv
// Core reset sequencer: holds core_nrst low for RST_CYCLES edges while start
// is high, then releases it; kill drives core_nrst low and rearms the count.
module core_rst_seq #(
   parameter int RST_CYCLES = 3
) (
   input  logic clk,
   input  logic nrst,
   input  logic start,
   input  logic kill,
   output logic release_now,
   output logic core_nrst
);

   localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   logic [RC_W-1:0] rst_cnt;

   assign release_now = start && !kill && (rst_cnt == RC_W'(RST_CYCLES - 1));

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rst_cnt   <= '0;
         core_nrst <= 1'b0;
      end else if (kill) begin
         rst_cnt   <= '0;
         core_nrst <= 1'b0;
      end else if (start) begin
         if (release_now) begin
            rst_cnt   <= '0;
            core_nrst <= 1'b1;
         end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
         end
      end else begin
         // outside HOLD the count sits at zero so a later restart begins clean
         rst_cnt <= '0;
      end
   end

endmodule

// File: rtl/core_trace_checker.sv
// Drives the core's reset, then checks each retirement (PC, write-back data)
// against an expected-trace table and reports pass / fail / timeout.
module core_trace_checker
   import core_tb_pkg::*;
#(
   parameter int PC_W         = 8,
   parameter int DATA_W       = 32,
   parameter int DEPTH        = 16,
   parameter int RST_CYCLES   = 3,
   parameter int TIMEOUT      = 64,
   parameter int CNT_W        = 16,
   parameter bit HALT_ON_FAIL = 1'b1,
   localparam int IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              restart,
   output logic              core_nrst,
   input  logic              retire_valid,
   input  logic [PC_W-1:0]   retire_pc,
   input  logic [DATA_W-1:0] retire_data,
   output logic [IDX_W-1:0]  exp_idx,
   input  logic [PC_W-1:0]   exp_pc,
   input  logic [DATA_W-1:0] exp_data,
   input  logic              exp_chk,
   input  logic              exp_last,
   output logic              done,
   output logic              pass,
   output logic [1:0]        err_code,
   output logic [IDX_W-1:0]  fail_idx,
   output logic [CNT_W-1:0]  cycle_cnt
);

   localparam int TO_W = $clog2(TIMEOUT);

   state_t           state, state_nxt;
   logic [TO_W-1:0]  idle_cnt, idle_nxt;
   logic [IDX_W-1:0] idx_nxt, fidx_nxt;
   logic [CNT_W-1:0] cyc_nxt;
   logic [1:0]       err_nxt;
   logic             pass_nxt;
   logic             terminal, release_now, kill;

   assign terminal = (state == ST_PASS) || (state == ST_FAIL) || (state == ST_TIMEOUT);
   assign kill     = (terminal && restart) ||
                     (HALT_ON_FAIL && ((state == ST_FAIL) || (state == ST_TIMEOUT)));

   core_rst_seq #(.RST_CYCLES(RST_CYCLES)) u_rst_seq (
      .clk         (clk),
      .nrst        (nrst),
      .start       (state == ST_HOLD),
      .kill        (kill),
      .release_now (release_now),
      .core_nrst   (core_nrst)
   );

   always_comb begin
      state_nxt = state;
      idle_nxt  = idle_cnt;
      idx_nxt   = exp_idx;
      fidx_nxt  = fail_idx;
      cyc_nxt   = cycle_cnt;
      err_nxt   = err_code;
      pass_nxt  = pass;
      case (state)
         ST_HOLD: if (release_now) state_nxt = ST_RUN;
         ST_RUN: begin
            if (cycle_cnt != '1) cyc_nxt = cycle_cnt + CNT_W'(1);
            if (retire_valid) begin
               idle_nxt = '0;
               // PC mismatch outranks data mismatch
               if (retire_pc != exp_pc) begin
                  state_nxt = ST_FAIL;
                  err_nxt   = ERR_PC;
                  fidx_nxt  = exp_idx;
               end else if (exp_chk && (retire_data != exp_data)) begin
                  state_nxt = ST_FAIL;
                  err_nxt   = ERR_DATA;
                  fidx_nxt  = exp_idx;
               end else if (exp_last || (exp_idx == IDX_W'(DEPTH - 1))) begin
                  state_nxt = ST_PASS;
                  pass_nxt  = 1'b1;
               end else begin
                  idx_nxt = exp_idx + IDX_W'(1);
               end
            end else if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
               state_nxt = ST_TIMEOUT;
               err_nxt   = ERR_TIMEOUT;
               fidx_nxt  = exp_idx;
            end else begin
               idle_nxt = idle_cnt + TO_W'(1);
            end
         end
         default: if (restart) begin
            state_nxt = ST_HOLD;
            idle_nxt  = '0;
            idx_nxt   = '0;
            fidx_nxt  = '0;
            cyc_nxt   = '0;
            err_nxt   = ERR_NONE;
            pass_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= ST_HOLD;
         idle_cnt  <= '0;
         exp_idx   <= '0;
         fail_idx  <= '0;
         cycle_cnt <= '0;
         err_code  <= ERR_NONE;
         pass      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         idle_cnt  <= idle_nxt;
         exp_idx   <= idx_nxt;
         fail_idx  <= fidx_nxt;
         cycle_cnt <= cyc_nxt;
         err_code  <= err_nxt;
         pass      <= pass_nxt;
         done      <= (state_nxt == ST_PASS) || (state_nxt == ST_FAIL) ||
                      (state_nxt == ST_TIMEOUT);
      end
   end

endmodule

// File: tb/tb_core_trace_checker.sv
// Directed bench for core_trace_checker: reset sequence, pass, PC/data
// mismatch, data mask, timeout boundary, restart and async reset.
module tb_core_trace_checker;

   logic        clk, nrst, restart, core_nrst;
   logic        retire_valid;
   logic [7:0]  retire_pc, exp_pc;
   logic [31:0] retire_data, exp_data;
   logic [3:0]  exp_idx, fail_idx;
   logic        exp_chk, exp_last, done, pass;
   logic [1:0]  err_code;
   logic [15:0] cycle_cnt;

   logic [7:0]  tbl_pc   [16];
   logic [31:0] tbl_data [16];
   logic        tbl_chk  [16];
   logic        tbl_last [16];

   int n_cmp = 0;
   int n_bad = 0;

   assign exp_pc   = tbl_pc[exp_idx];
   assign exp_data = tbl_data[exp_idx];
   assign exp_chk  = tbl_chk[exp_idx];
   assign exp_last = tbl_last[exp_idx];

   core_trace_checker dut (
      .clk          (clk),
      .nrst         (nrst),
      .restart      (restart),
      .core_nrst    (core_nrst),
      .retire_valid (retire_valid),
      .retire_pc    (retire_pc),
      .retire_data  (retire_data),
      .exp_idx      (exp_idx),
      .exp_pc       (exp_pc),
      .exp_data     (exp_data),
      .exp_chk      (exp_chk),
      .exp_last     (exp_last),
      .done         (done),
      .pass         (pass),
      .err_code     (err_code),
      .fail_idx     (fail_idx),
      .cycle_cnt    (cycle_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic retire(input logic [7:0] pc, input logic [31:0] data);
      retire_valid = 1'b1;
      retire_pc    = pc;
      retire_data  = data;
      tick();
      retire_valid = 1'b0;
   endtask

   task automatic do_restart();
      restart = 1'b1;
      tick();
      restart = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         tbl_pc[i]   = 8'(i);
         tbl_data[i] = 32'h100 + 32'(i);
         tbl_chk[i]  = 1'b1;
         tbl_last[i] = 1'b0;
      end
      tbl_data[8] = 32'h3;
      tbl_last[8] = 1'b1;
      tbl_chk[2]  = 1'b0;

      nrst = 1'b1; restart = 1'b0; retire_valid = 1'b0;
      retire_pc = '0; retire_data = '0;
      #2 nrst = 1'b0;
      #1;
      chk("rst_core_nrst", core_nrst, 0);
      chk("rst_done", done, 0);
      chk("rst_idx", exp_idx, 0);
      repeat (5) tick();
      chk("rst_err", err_code, 0);
      chk("rst_cyc", cycle_cnt, 0);

      // reset sequence: core_nrst rises on 3rd edge
      nrst = 1'b1;
      tick(); chk("seq_e1", core_nrst, 0);
      tick(); chk("seq_e2", core_nrst, 0);
      tick(); chk("seq_e3", core_nrst, 1);
      chk("seq_cyc", cycle_cnt, 0);

      // full pass; entry 2 data masked
      for (int i = 0; i < 9; i++) begin
         if (i == 8) chk("pass_pre_done", done, 0);
         retire(8'(i), (i == 2) ? 32'hdead : tbl_data[i]);
      end
      chk("pass_done", done, 1);
      chk("pass_pass", pass, 1);
      chk("pass_err", err_code, 0);
      chk("pass_idx", exp_idx, 8);
      chk("pass_cyc", cycle_cnt, 9);
      repeat (3) tick();
      chk("pass_cyc_frz", cycle_cnt, 9);
      chk("pass_core_nrst", core_nrst, 1);

      // restart clears status
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("rs_state_core_nrst", core_nrst, 0);
      chk("rs_done", done, 0);
      chk("rs_pass", pass, 0);
      chk("rs_idx", exp_idx, 0);
      chk("rs_cyc", cycle_cnt, 0);
      repeat (3) tick();
      chk("rs_core_nrst_up", core_nrst, 1);

      // PC mismatch at entry 4
      for (int i = 0; i < 4; i++) retire(8'(i), tbl_data[i]);
      retire(8'h05, tbl_data[4]);
      chk("pc_done", done, 1);
      chk("pc_err", err_code, 1);
      chk("pc_fidx", fail_idx, 4);
      chk("pc_core_nrst_hold", core_nrst, 1);
      tick();
      chk("pc_core_nrst_drop", core_nrst, 0);
      retire(8'h00, 32'h0);
      chk("pc_err_frz", err_code, 1);

      // data mismatch at entry 8
      do_restart();
      for (int i = 0; i < 8; i++) retire(8'(i), (i == 2) ? 32'hbeef : tbl_data[i]);
      chk("dm_mask_ok", done, 0);
      retire(8'h08, 32'h2);
      chk("dm_err", err_code, 2);
      chk("dm_fidx", fail_idx, 8);

      // timeout boundary
      do_restart();
      repeat (63) tick();
      retire(8'h00, tbl_data[0]);
      chk("to_edge_done", done, 0);
      chk("to_edge_idx", exp_idx, 1);
      repeat (63) tick();
      chk("to_63_done", done, 0);
      tick();
      chk("to_done", done, 1);
      chk("to_err", err_code, 3);
      chk("to_fidx", fail_idx, 1);
      chk("to_cyc", cycle_cnt, 128);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("to_rs_err", err_code, 0);
      chk("to_rs_cyc", cycle_cnt, 0);
      repeat (3) tick();

      // PC and data both wrong: PC wins
      retire(8'h07, 32'hffff);
      chk("prio_err", err_code, 1);
      chk("prio_fidx", fail_idx, 0);

      // async reset mid-RUN
      do_restart();
      for (int i = 0; i < 5; i++) retire(8'(i), tbl_data[i]);
      chk("ar_idx_pre", exp_idx, 5);
      #3 nrst = 1'b0;
      #1;
      chk("ar_core_nrst", core_nrst, 0);
      chk("ar_idx", exp_idx, 0);
      chk("ar_done", done, 0);
      chk("ar_cyc", cycle_cnt, 0);
      tick();
      nrst = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/core_trace_checker.md
Name: core_trace_checker

Overview:
- Synthesizable, parametrised successor to the core bench harness.
- Generates the core's reset sequence, watches the core's retirement stream (PC and write-back data), and compares each retirement against an expected-trace table.
- Reports pass, fail or timeout with the failing index and error code.
- Sits beside Core, both on FPGA and in simulation, replacing free-running "run for N ns and eyeball" checking.

Parameters:
- PC_W, 8, width of PC / retirement address.
- DATA_W, 32, width of write-back data.
- DEPTH, 16, number of expected-trace entries; IDX_W = clog2(DEPTH).
- RST_CYCLES, 3, clock edges core_nrst is held low after nrst deasserts (≥1).
- TIMEOUT, 64, consecutive cycles without retirement before timeout (≥2).
- CNT_W, 16, width of cycle counter.
- HALT_ON_FAIL, 1, 1 = drive core_nrst low again on FAIL/TIMEOUT.

Ports:
- clk, input, 1, system clock.
- nrst, input, 1, asynchronous active-low reset.
- restart, input, 1, single-cycle pulse; restarts the sequence from a terminal state.
- core_nrst, output, 1, reset to Core, active-low.
- retire_valid, input, 1, Core retired an instruction this cycle.
- retire_pc, input, PC_W, PC of retired instruction.
- retire_data, input, DATA_W, reg_din written by retired instruction.
- exp_idx, output, IDX_W, index into expected-trace table.
- exp_pc, input, PC_W, expected PC at exp_idx (combinational read, same cycle).
- exp_data, input, DATA_W, expected write-back data.
- exp_chk, input, 1, 1 = compare data for this entry.
- exp_last, input, 1, entry is the final expected retirement.
- done, output, 1, terminal state reached.
- pass, output, 1, trace matched completely.
- err_code, output, 2, error code: 0 none, 1 PC mismatch, 2 data mismatch, 3 timeout.
- fail_idx, output, IDX_W, exp_idx at failure.
- cycle_cnt, output, CNT_W, cycles spent in RUN, saturating.

Behaviour:
- Reset: one clock domain; reset is asynchronous and active-low on nrst.
  - While nrst=0: core_nrst=0 (asynchronously), state=HOLD, rst_cnt=0, exp_idx=0, idle_cnt=0, cycle_cnt=0, done=0, pass=0, err_code=0, fail_idx=0.
  - Reset mid-operation aborts everything to these values.
- States: HOLD, RUN, PASS, FAIL, TIMEOUT. All outputs are registered.
- HOLD:
  - rst_cnt increments each edge.
  - On the edge where rst_cnt==RST_CYCLES-1: core_nrst<=1, state<=RUN.
  - core_nrst therefore rises on the RST_CYCLES-th rising edge after nrst deasserts.
  - retire_valid is ignored.
- RUN:
  - cycle_cnt increments each cycle and saturates at all-ones.
  - On retire_valid:
    - PC mismatch (retire_pc≠exp_pc) → FAIL, err_code=1.
    - Otherwise, exp_chk=1 and retire_data≠exp_data → FAIL, err_code=2.
    - PC mismatch has priority over data mismatch.
    - On mismatch, fail_idx<=exp_idx.
    - On match with exp_last=1 or exp_idx==DEPTH-1 → PASS, pass=1.
    - On any other match: exp_idx<=exp_idx+1; it never wraps.
  - idle_cnt clears on retire_valid and otherwise increments.
  - When idle_cnt==TIMEOUT-1 and retire_valid=0 → TIMEOUT, err_code=3, fail_idx=exp_idx.
  - retire_valid in the same cycle as the timeout threshold: the retirement is evaluated and the timeout does not occur.
- PASS / FAIL / TIMEOUT:
  - done=1; all status outputs and cycle_cnt are frozen.
  - core_nrst stays 1 in PASS.
  - In FAIL/TIMEOUT, core_nrst<=0 the next edge if HALT_ON_FAIL=1; otherwise it stays 1.
  - retire_valid is ignored.
- restart:
  - In a terminal state → HOLD with all counters and status cleared (core_nrst<=0).
  - Ignored in HOLD and RUN.
- Latency:
  - A mismatch is visible on done/err_code one edge after the offending retire_valid cycle.

Decomposition:
- Package core_tb_pkg: state enum (HOLD, RUN, PASS, FAIL, TIMEOUT), err_code constants ERR_NONE/ERR_PC/ERR_DATA/ERR_TIMEOUT.
- Sub-module core_rst_seq holds rst_cnt and the core_nrst register, with ports clk, nrst, start, release, core_nrst.
- Compare logic and FSM stay in the top block.

Test Plan:
- Reset sequence: nrst low 5 cycles then high, RST_CYCLES=3 → core_nrst=0 for exactly 3 edges after release, then 1; state RUN.
- Full pass: table of 9 entries (pc 0..8, entry 8 data 0x3, exp_last=1), core retires pc 0..8 with matching data → pass=1, done=1 one edge after pc 8, exp_idx=8.
- PC mismatch: at entry 4 core retires pc 0x05 against expected 0x04 → err_code=1, fail_idx=4, core_nrst drops next edge (HALT_ON_FAIL=1).
- Data mismatch with mask: entry 2 exp_chk=0 and data differs → no fail. Entry 8 exp_chk=1, 0x2 vs 0x3 → err_code=2, fail_idx=8.
- Timeout boundary, TIMEOUT=64: no retire for 63 cycles then retire on the 64th → continues. Later 64 idle cycles → err_code=3. restart pulse → HOLD, err_code=0, cycle_cnt=0.
- Async reset mid-RUN at exp_idx=5: nrst low mid-cycle → core_nrst=0 immediately, exp_idx=0, done=0, without waiting for a clock edge.
